semi_auto_cmd_conditioner: RTL and testbench
============================================

SEMI_AUTO_CMD_CONDITIONER -- requirements
Module: semi_auto_cmd_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2000000, consecutive stable clk cycles required to accept a button level change (20 ms at 100 MHz).
REQ-002 Parameter HOLD_CYCLES, default 3000000, clk cycles a command output stays asserted (30 ms, at least 3 periods of the downstream 100 Hz sampler).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 semi_auto_mode_on  input  1  block enable; 0 forces idle with all commands low.
REQ-006 btn_up, btn_right, btn_left, btn_down  input  1 each  raw asynchronous push buttons, active-high.
REQ-007 go_straight_command, turn_right_command, turn_left_command, turn_back_command  output  1 each  held one-hot command pulses to the semi-auto driving FSM.
REQ-008 cmd_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Each synchronized button SHALL drive its own debounce counter (32-bit) and debounced level; the level SHALL update on the edge where the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle SHALL clear the counter.
REQ-011 A request SHALL be a 0->1 transition of a debounced level, lasting exactly one cycle.
REQ-012 Request priority SHALL be up > right > left > down; only the highest simultaneous request SHALL be accepted and the others discarded.
REQ-013 FSM states SHALL be IDLE, HOLD and RELEASE.
REQ-014 IDLE: on a request while semi_auto_mode_on=1, the FSM SHALL latch the one-hot command, clear the hold counter and enter HOLD on the next edge.
REQ-015 HOLD: exactly one command output SHALL be high for exactly HOLD_CYCLES cycles; on the cycle the counter reaches HOLD_CYCLES-1 the FSM SHALL clear the outputs and enter RELEASE.
REQ-016 Requests arriving in HOLD or RELEASE SHALL be dropped, not queued.
REQ-017 RELEASE behaviour is set by REQ-024/REQ-025.
REQ-018 When semi_auto_mode_on=0 in any state, the next edge SHALL force IDLE, clear all command outputs and clear the hold counter; debouncers SHALL keep running.
REQ-019 Latency: with a clean raw press, the command output SHALL rise exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples the raw button high.
REQ-020 Command outputs SHALL be registered and never glitch; more than one command SHALL never be high.

Reset
REQ-021 reset=0 SHALL, on the next edge, set state IDLE, all outputs 0, hold counter 0, debounce counters 0, and debounced levels and synchronizers 0.
REQ-022 Reset asserted during HOLD SHALL drop the command within one cycle, with no residual pulse after release.
REQ-023 After reset is released, a button already held SHALL be treated as a new press: a rising debounced level after DEBOUNCE_CYCLES, producing one command.

Configuration
REQ-024 With macro CMD_RELEASE_WAIT_EN defined, RELEASE SHALL stay until all four debounced levels are 0, then enter IDLE; a held button therefore yields exactly one command.
REQ-025 Without CMD_RELEASE_WAIT_EN, RELEASE SHALL last exactly one cycle and then enter IDLE; because requests are edge-only, a held button still yields one command.
REQ-026 cmd_busy SHALL include the RELEASE cycles in both builds.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-027 Reset, then btn_right held high from edge 0 -> turn_right_command high on edges 7..14 only; the other commands stay 0.
REQ-028 btn_up and btn_left rise on the same edge -> only go_straight_command pulses for 8 cycles; no turn_left_command at any time.
REQ-029 btn_down toggles every 2 cycles for 20 cycles, then stays low -> no command output, cmd_busy stays 0.
REQ-030 During HOLD of go_straight_command, btn_left is pressed -> left press dropped; with CMD_RELEASE_WAIT_EN, cmd_busy stays high until both buttons are debounced low.
REQ-031 reset=0 at the 3rd HOLD cycle -> command low on the next edge; with btn held through release, one fresh 8-cycle pulse starts DEBOUNCE_CYCLES+3 edges later.
REQ-032 semi_auto_mode_on=0 mid-HOLD -> outputs 0 and cmd_busy 0 on the next edge; a press while disabled produces no command.

Source files
------------

// File: rtl/semi_auto_cmd_conditioner_if.sv
// +-----------------------------------------------------------------------------+
// | semi_auto_cmd_conditioner_if : button inputs and held command outputs        |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface semi_auto_cmd_conditioner_if;
  logic semi_auto_mode_on;
  logic btn_up;
  logic btn_right;
  logic btn_left;
  logic btn_down;
  logic go_straight_command;
  logic turn_right_command;
  logic turn_left_command;
  logic turn_back_command;
  logic cmd_busy;

  modport master (
    output semi_auto_mode_on, btn_up, btn_right, btn_left, btn_down,
    input  go_straight_command, turn_right_command, turn_left_command,
           turn_back_command, cmd_busy
  );

  modport slave (
    input  semi_auto_mode_on, btn_up, btn_right, btn_left, btn_down,
    output go_straight_command, turn_right_command, turn_left_command,
           turn_back_command, cmd_busy
  );
endinterface

`default_nettype wire

// File: rtl/semi_auto_cmd_conditioner.sv
// +-----------------------------------------------------------------------------+
// | semi_auto_cmd_conditioner : sync + debounce four buttons, emit one held     |
// | one-hot command per press. Optional macro: CMD_RELEASE_WAIT_EN.  Rev 1.0     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module semi_auto_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int HOLD_CYCLES     = 3000000
) (
  input  logic                          clk,
  input  logic                          reset,
  semi_auto_cmd_conditioner_if.slave    bus
);

  localparam logic [31:0] c_db_last   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] c_hold_last = 32'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Bit order throughout: [3]=up, [2]=right, [1]=left, [0]=down.
  logic [3:0] w_raw;
  logic [3:0] w_level;
  logic [3:0] w_rise;
  logic [3:0] w_req;
  logic [3:0] r_level_d;
  logic [3:0] r_req;
  logic [3:0] r_cmd;
  logic [31:0] r_hold_cnt;
  logic        r_busy;
  state_t      r_state;

  assign w_raw = {bus.btn_up, bus.btn_right, bus.btn_left, bus.btn_down};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_btn
      logic        r_sync1;
      logic        r_sync2;
      logic        r_level;
      logic [31:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_level <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_raw[i];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == c_db_last) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
      end

      assign w_level[i] = r_level;
    end
  endgenerate

  assign w_rise = w_level & ~r_level_d;

  always_comb begin
    w_req = 4'b0000;
    if (w_rise[3])      w_req = 4'b1000;
    else if (w_rise[2]) w_req = 4'b0100;
    else if (w_rise[1]) w_req = 4'b0010;
    else if (w_rise[0]) w_req = 4'b0001;
  end

  // Request pulse is registered so the FSM sees a clean single-cycle one-hot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_level_d <= 4'b0000;
      r_req     <= 4'b0000;
    end else begin
      r_level_d <= w_level;
      r_req     <= w_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cmd      <= 4'b0000;
      r_hold_cnt <= '0;
      r_busy     <= 1'b0;
    end else if (!bus.semi_auto_mode_on) begin
      r_state    <= ST_IDLE;
      r_cmd      <= 4'b0000;
      r_hold_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_req != 4'b0000) begin
            r_cmd      <= r_req;
            r_hold_cnt <= '0;
            r_state    <= ST_HOLD;
            r_busy     <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == c_hold_last) begin
            r_cmd   <= 4'b0000;
            r_state <= ST_RELEASE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
          end
        end
        ST_RELEASE: begin
`ifdef CMD_RELEASE_WAIT_EN
          if (w_level == 4'b0000) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
`else
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cmd      <= 4'b0000;
          r_hold_cnt <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.go_straight_command = r_cmd[3];
  assign bus.turn_right_command  = r_cmd[2];
  assign bus.turn_left_command   = r_cmd[1];
  assign bus.turn_back_command   = r_cmd[0];
  assign bus.cmd_busy            = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_semi_auto_cmd_conditioner.sv
// +-----------------------------------------------------------------------------+
// | tb_semi_auto_cmd_conditioner : scoreboard bench, DEBOUNCE=4, HOLD=8         |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_semi_auto_cmd_conditioner;
  localparam int c_db   = 4;
  localparam int c_hold = 8;
  localparam int c_lat  = c_db + 3;
  localparam logic [3:0] c_up    = 4'b1000;
  localparam logic [3:0] c_right = 4'b0100;
  localparam logic [3:0] c_left  = 4'b0010;
  localparam logic [3:0] c_down  = 4'b0001;
`ifdef CMD_RELEASE_WAIT_EN
  localparam int c_wait = 1;
`else
  localparam int c_wait = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  semi_auto_cmd_conditioner_if bus();

  semi_auto_cmd_conditioner #(
    .DEBOUNCE_CYCLES(c_db),
    .HOLD_CYCLES    (c_hold)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] cmd;
    int         start;
    int         len;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   onehot_err = 0;
  logic [3:0] cmds;

  assign cmds = {bus.go_straight_command, bus.turn_right_command,
                 bus.turn_left_command, bus.turn_back_command};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [3:0] c, input int start, input int len);
    sb.push_back('{cmd: c, start: start, len: len});
  endtask

  // Monitor: each completed command pulse is matched against the next expectation.
  logic [3:0] m_cmd = 4'b0000;
  int         m_start = 0;
  int         m_len = 0;
  bit         m_on = 1'b0;
  exp_t       m_exp;

  always @(negedge clk) begin
    if (cmds != 4'b0000 && !$onehot(cmds)) onehot_err++;
    if (m_on && cmds != m_cmd) begin
      m_on = 1'b0;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: actual cmd=%b start=%0d len=%0d, required no pulse",
                 m_cmd, m_start, m_len);
      end else begin
        m_exp = sb.pop_front();
        chk("pulse_cmd",   int'(m_cmd), int'(m_exp.cmd));
        chk("pulse_start", m_start,     m_exp.start);
        chk("pulse_len",   m_len,       m_exp.len);
      end
    end
    if (!m_on && cmds != 4'b0000) begin
      m_on    = 1'b1;
      m_cmd   = cmds;
      m_start = edge_cnt - 1;
      m_len   = 1;
    end else if (m_on) begin
      m_len++;
    end
  end

  int t0;
  int t1;
  bit busy_seen;

  initial begin
    bus.semi_auto_mode_on = 1'b1;
    bus.btn_up    = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_down  = 1'b0;
    reset = 1'b0;
    tick(3);
    chk("reset_cmds", int'(cmds), 0);
    chk("reset_busy", int'(bus.cmd_busy), 0);
    reset = 1'b1;
    tick(5);

    // Held right press: one pulse, latency DEBOUNCE+3, length HOLD.
    t0 = edge_cnt;
    bus.btn_right = 1'b1;
    expect_pulse(c_right, t0 + c_lat, c_hold);
    tick(10);
    chk("busy_in_hold", int'(bus.cmd_busy), 1);
    tick(10);
    chk("busy_while_held", int'(bus.cmd_busy), c_wait);
    bus.btn_right = 1'b0;
    tick(15);
    chk("busy_after_release", int'(bus.cmd_busy), 0);

    // Simultaneous up + left: up wins, left discarded.
    t0 = edge_cnt;
    bus.btn_up   = 1'b1;
    bus.btn_left = 1'b1;
    expect_pulse(c_up, t0 + c_lat, c_hold);
    tick(20);
    bus.btn_up   = 1'b0;
    bus.btn_left = 1'b0;
    tick(15);

    // Bouncing down button never debounces.
    busy_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.btn_down = (k % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        if (bus.cmd_busy) busy_seen = 1'b1;
      end
    end
    bus.btn_down = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.cmd_busy) busy_seen = 1'b1;
    end
    chk("bounce_busy", int'(busy_seen), 0);

    // Left pressed during HOLD of up is dropped.
    t0 = edge_cnt;
    bus.btn_up = 1'b1;
    expect_pulse(c_up, t0 + c_lat, c_hold);
    tick(8);
    bus.btn_left = 1'b1;
    bus.btn_up   = 1'b0;
    tick(17);
    chk("busy_left_held", int'(bus.cmd_busy), c_wait);
    bus.btn_left = 1'b0;
    tick(15);
    chk("busy_left_released", int'(bus.cmd_busy), 0);

    // Reset on third HOLD cycle, button held through release.
    t0 = edge_cnt;
    bus.btn_right = 1'b1;
    expect_pulse(c_right, t0 + c_lat, 3);
    tick(10);
    reset = 1'b0;
    tick(1);
    chk("reset_drop_cmds", int'(cmds), 0);
    chk("reset_drop_busy", int'(bus.cmd_busy), 0);
    tick(1);
    t1 = edge_cnt;
    reset = 1'b1;
    expect_pulse(c_right, t1 + c_lat, c_hold);
    tick(25);
    bus.btn_right = 1'b0;
    tick(15);

    // Mode off mid-HOLD, then a press while disabled.
    t0 = edge_cnt;
    bus.btn_left = 1'b1;
    expect_pulse(c_left, t0 + c_lat, 4);
    tick(11);
    bus.semi_auto_mode_on = 1'b0;
    tick(1);
    chk("disable_cmds", int'(cmds), 0);
    chk("disable_busy", int'(bus.cmd_busy), 0);
    bus.btn_left = 1'b0;
    tick(10);
    bus.btn_down = 1'b1;
    tick(12);
    chk("disabled_press_busy", int'(bus.cmd_busy), 0);
    bus.btn_down = 1'b0;
    tick(10);
    bus.semi_auto_mode_on = 1'b1;
    tick(10);

    // Lowest-priority button alone still produces its command.
    t0 = edge_cnt;
    bus.btn_down = 1'b1;
    expect_pulse(c_down, t0 + c_lat, c_hold);
    tick(20);
    bus.btn_down = 1'b0;
    tick(15);

    chk("scoreboard_empty", sb.size(), 0);
    chk("onehot_violations", onehot_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
